regfile_dump: RTL and testbench

- Debug read-out engine for the 32x32 integer register file.
- Drives one register-file read port, which has a combinational address-to-data path.
- Streams a contiguous, optionally wrapping range of registers onto a valid/ready output channel, one word per cycle when the sink never stalls.
- Sits beside the core's register file on the debug path and acts as the initiator of register-file reads.

---
 rtl/regfile_dump.sv | 103 ++++++++++
 tb/tb_regfile_dump.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: streams a contiguous (optionally wrapping) range of the 32x32
// integer register file onto a valid/ready channel. It owns one combinational
// read port and captures each word at the edge that presents it.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last_q;     // end of range, frozen at the accepted start
    logic [ADDR_W-1:0] idx_nxt;
    logic              hs;
    logic              at_last;

    // Index arithmetic wraps naturally at ADDR_W bits.
    assign idx_nxt  = out_idx + ADDR_W'(1);
    assign hs       = out_valid && out_ready;
    assign at_last  = (out_idx == last_q);
    assign out_last = out_valid && at_last;

    // Read address: the register that the next capture edge will sample.
    always_comb begin
        rf_addr = out_idx;
        case (state)
            IDLE:    rf_addr = first_idx;
            SEND:    rf_addr = idx_nxt;
            default: rf_addr = out_idx;
        endcase
    end

    // Dump sequencer: capture on start/handshake, abort back to IDLE, pulse done.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            last_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        out_data  <= rf_data;
                        out_idx   <= first_idx;
                        last_q    <= last_idx;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a same-cycle handshake; that beat is
                    // still delivered but nothing follows and done stays low
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (hs) begin
                        if (at_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_data <= rf_data;
                            out_idx  <= idx_nxt;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file plus a range model
// (index list from first/last modulo 32, data from the register array).
module tb_regfile_dump;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  first_idx = '0;
    logic [4:0]  last_idx = '0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        wr_en = 1'b0;
    logic [4:0]  wr_a = '0;
    logic [31:0] wr_d = '0;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    bit chain = 1'b0;

    int          q_idx[$];
    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_cyc[$];
    int          e_idx[$];
    logic [31:0] e_data[$];

    regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .first_idx(first_idx), .last_idx(last_idx), .abort(abort),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // register file: writes commit at the edge, reads are combinational, x0 reads 0
    always @(posedge clock) if (wr_en) regs[wr_a] <= wr_d;
    assign rf_data = (rf_addr == 5'd0) ? 32'h0 : regs[rf_addr];

    task automatic sample();
        @(negedge clock);
        cyc++;
        if (done) begin done_cnt++; done_cyc = cyc; end
    endtask

    // Set the inputs for the coming edge; log a beat if it handshakes there.
    task automatic drive(input bit rdy, input bit ab = 1'b0, input bit st = 1'b0,
                         input bit we = 1'b0, input logic [4:0] wa = '0,
                         input logic [31:0] wd = '0);
        if (out_valid && rdy && reset_n) begin
            q_idx.push_back(int'(out_idx)); q_data.push_back(out_data);
            q_last.push_back(out_last);     q_cyc.push_back(cyc);
        end
        out_ready = rdy; abort = ab; start = st; wr_en = we; wr_a = wa; wr_d = wd;
    endtask

    task automatic clear_log();
        q_idx.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    // Expected stream: ((l-f) mod 32)+1 indices from f upward, wrapping.
    task automatic build_model(input logic [4:0] f, input logic [4:0] l);
        int len;
        e_idx.delete(); e_data.delete();
        len = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int k = 0; k < len; k++) begin
            int i;
            i = (int'(f) + k) % 32;
            e_idx.push_back(i);
            e_data.push_back(i == 0 ? 32'h0 : regs[i]);
        end
    endtask

    // One dump. ev_kind fires once when beat ev_idx is on the bus:
    // 1 write wa=wd, 2 abort, 3 new start with a different range, 4 reset.
    task automatic run(input logic [4:0] f, input logic [4:0] l, input int pct,
                       input int ev_idx, input int ev_kind, input logic [4:0] wa,
                       input logic [31:0] wd, output bit to);
        clear_log();
        first_idx = f; last_idx = l; to = 1'b1;
        if (!chain) sample();
        chain = 1'b0;
        start_cyc = cyc;
        drive(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            sample();
            if (!busy) begin to = 1'b0; break; end
            if (ev_kind != 0 && out_valid && int'(out_idx) == ev_idx) begin
                case (ev_kind)
                    1: drive(1'b1, 1'b0, 1'b0, 1'b1, wa, wd);
                    2: drive(1'b1, 1'b1);
                    3: begin first_idx = 5'd20; last_idx = 5'd25; drive(1'b1, 1'b0, 1'b1); end
                    default: begin reset_n = 1'b0; drive(1'b1); end
                endcase
            end else begin
                drive($urandom_range(99) < pct);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; first_idx = 5'd3;
        repeat (2) sample();
        checks++;
        if ({out_valid, out_last, busy, done, out_idx, out_data} !== '0)
            $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b idx=%0d data=%h want all 0",
                     out_valid, out_last, busy, done, out_idx, out_data);
        if ({out_valid, out_last, busy, done, out_idx, out_data} !== '0) errors++;
        drive(1'b0);
        reset_n = 1'b1;
        sample();
        checks++;
        if (rf_addr !== 5'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rf_addr got addr=%0d busy=%b want addr=3 busy=0", rf_addr, busy);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) begin
            sample();
            drive(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 32'(i) * 32'h11111111);
        end
    endtask

    task automatic test_full_dump();
        bit to;
        run(5'd0, 5'd31, 100, -1, 0, '0, '0, to);
        build_model(5'd0, 5'd31);
        checks++;
        if (to || q_idx.size() != 32) begin
            errors++; $display("FAIL full_count got %0d beats to=%b want 32", q_idx.size(), to);
        end
        for (int k = 0; k < q_idx.size() && k < 32; k++) begin
            checks++;
            if (q_idx[k] != e_idx[k] || q_data[k] !== e_data[k] || q_last[k] != (k == 31)
                || q_cyc[k] != start_cyc + 1 + k) begin
                errors++;
                $display("FAIL full_beat%0d got idx=%0d data=%h last=%b cyc=%0d want idx=%0d data=%h last=%b cyc=%0d",
                         k, q_idx[k], q_data[k], q_last[k], q_cyc[k], e_idx[k], e_data[k], k == 31, start_cyc + 1 + k);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != start_cyc + 33 || cyc != start_cyc + 34) begin
            errors++;
            $display("FAIL full_done got cnt=%0d at=%0d idle=%0d want cnt=1 at=%0d idle=%0d",
                     done_cnt, done_cyc - start_cyc, cyc - start_cyc, 33, 34);
        end
    endtask

    task automatic test_backpressure();
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit r, pv, pr, to;
        logic [4:0] pidx;
        logic [31:0] pdata;
        clear_log(); build_model(5'd4, 5'd6);
        first_idx = 5'd4; last_idx = 5'd6; pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0; to = 1'b1;
        sample(); drive(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            sample();
            if (!busy) begin to = 1'b0; break; end
            if (pv && !pr) begin
                checks++;
                if (!out_valid || out_idx !== pidx || out_data !== pdata) begin
                    errors++;
                    $display("FAIL bp_stall got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                             out_valid, out_idx, out_data, pidx, pdata);
                end
            end
            r = (k < 6) ? pat[k] : 1'b1;
            pv = out_valid; pr = r; pidx = out_idx; pdata = out_data;
            drive(r);
        end
        checks++;
        if (to || q_idx.size() != 3 || done_cnt != 1) begin
            errors++; $display("FAIL bp_count got %0d beats done=%0d to=%b want 3 beats done=1", q_idx.size(), done_cnt, to);
        end
        for (int k = 0; k < q_idx.size() && k < 3; k++) begin
            checks++;
            if (q_idx[k] != e_idx[k] || q_data[k] !== e_data[k] || q_last[k] != (k == 2)) begin
                errors++;
                $display("FAIL bp_beat%0d got idx=%0d data=%h want idx=%0d data=%h", k, q_idx[k], q_data[k], e_idx[k], e_data[k]);
            end
        end
    endtask

    // Ranges from the table, then random ranges/contents/backpressure.
    task automatic test_ranges(input bit rnd);
        logic [4:0] fs [3] = '{5'd30, 5'd5, 5'd10};
        logic [4:0] ls [3] = '{5'd1, 5'd5, 5'd9};
        logic [4:0] f, l;
        int n, pct;
        bit to;
        n = rnd ? 8 : 3;
        for (int c = 0; c < n; c++) begin
            if (rnd) begin
                for (int w = 0; w < 4; w++) begin
                    sample(); drive(1'b0, 1'b0, 1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom);
                end
                f = 5'($urandom_range(31)); l = 5'($urandom_range(31)); pct = $urandom_range(30, 100);
            end else begin
                f = fs[c]; l = ls[c]; pct = 100;
            end
            run(f, l, pct, -1, 0, '0, '0, to);
            build_model(f, l);
            checks++;
            if (to || q_idx.size() != e_idx.size() || done_cnt != 1) begin
                errors++;
                $display("FAIL range_%0d_%0d_count got %0d beats done=%0d to=%b want %0d beats done=1",
                         f, l, q_idx.size(), done_cnt, to, e_idx.size());
            end
            for (int k = 0; k < q_idx.size() && k < e_idx.size(); k++) begin
                checks++;
                if (q_idx[k] != e_idx[k] || q_data[k] !== e_data[k] || q_last[k] != (k == e_idx.size() - 1)) begin
                    errors++;
                    $display("FAIL range_%0d_%0d_beat%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             f, l, k, q_idx[k], q_data[k], q_last[k], e_idx[k], e_data[k], k == e_idx.size() - 1);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit to;
        run(5'd0, 5'd31, 100, 3, 2, '0, '0, to);
        build_model(5'd0, 5'd3);
        checks++;
        if (to || out_valid !== 1'b0 || done_cnt != 0 || q_idx.size() != 4) begin
            errors++;
            $display("FAIL abort_stop got v=%b done=%0d beats=%0d to=%b want v=0 done=0 beats=4",
                     out_valid, done_cnt, q_idx.size(), to);
        end
        for (int k = 0; k < q_idx.size() && k < 4; k++) begin
            checks++;
            if (q_idx[k] != e_idx[k] || q_data[k] !== e_data[k]) begin
                errors++;
                $display("FAIL abort_beat%0d got idx=%0d data=%h want idx=%0d data=%h", k, q_idx[k], q_data[k], e_idx[k], e_data[k]);
            end
        end
        chain = 1'b1;
        run(5'd2, 5'd3, 100, -1, 0, '0, '0, to);
        build_model(5'd2, 5'd3);
        checks++;
        if (to || q_idx.size() != 2 || done_cnt != 1 || q_idx[0] != 2 || q_data[0] !== e_data[0]
            || q_idx[1] != 3 || !q_last[1]) begin
            errors++;
            $display("FAIL abort_restart got beats=%0d done=%0d to=%b want beats=2 idx 2,3 done=1",
                     q_idx.size(), done_cnt, to);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        run(5'd0, 5'd31, 100, 10, 4, '0, '0, to);
        checks++;
        if (to || {out_valid, out_last, busy, done, out_idx, out_data} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got v=%b b=%b d=%b idx=%0d data=%h to=%b want all 0",
                     out_valid, busy, done, out_idx, out_data, to);
        end
        n = q_idx.size();
        drive(1'b1);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin sample(); drive(1'b1); end
        checks++;
        if (q_idx.size() != 10 || n != 10 || done_cnt != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet got beats=%0d done=%0d v=%b want beats=10 done=0 v=0",
                     q_idx.size(), done_cnt, out_valid);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        run(5'd0, 5'd7, 100, 3, 3, '0, '0, to);
        build_model(5'd0, 5'd7);
        checks++;
        if (to || q_idx.size() != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_ign_count got beats=%0d done=%0d to=%b want beats=8 done=1", q_idx.size(), done_cnt, to);
        end
        for (int k = 0; k < q_idx.size() && k < 8; k++) begin
            checks++;
            if (q_idx[k] != e_idx[k] || q_data[k] !== e_data[k]) begin
                errors++;
                $display("FAIL start_ign_beat%0d got idx=%0d want idx=%0d", k, q_idx[k], e_idx[k]);
            end
        end
    endtask

    task automatic test_concurrent_write();
        logic [31:0] old, got;
        bit to;
        old = regs[7];
        // write commits at the same edge that captures register 7
        run(5'd5, 5'd9, 100, 6, 1, 5'd7, 32'hDEADBEEF, to);
        got = 32'h0;
        foreach (q_idx[k]) if (q_idx[k] == 7) got = q_data[k];
        checks++;
        if (to || got !== old || q_idx.size() != 5) begin
            errors++;
            $display("FAIL cw_same_edge got %h beats=%0d want %h beats=5", got, q_idx.size(), old);
        end
        sample(); drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, old);
        // write commits two edges before the capture
        run(5'd3, 5'd9, 100, 4, 1, 5'd7, 32'hDEADBEEF, to);
        got = 32'h0;
        foreach (q_idx[k]) if (q_idx[k] == 7) got = q_data[k];
        checks++;
        if (to || got !== 32'hDEADBEEF || q_idx.size() != 7) begin
            errors++;
            $display("FAIL cw_early got %h beats=%0d want deadbeef beats=7", got, q_idx.size());
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_full_dump();
        test_backpressure();
        test_ranges(1'b0);
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_concurrent_write();
        test_ranges(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
